// File: rtl/mips_defs.sv
// Shared definitions for the fetch stage.
//   fetchStateT     : fetch FSM encodings (BOOT=0, RUN=1, HALT=2)
//   Nop             : instruction word presented when IF/ID holds nothing
//   DefaultMemWords : default instruction memory depth in words
package mips_defs;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetchStateT;

  localparam logic [31:0] Nop             = 32'h0000_0000;
  localparam int unsigned DefaultMemWords = 256;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register between fetch and decode.
// Ports:
//   Clock, Reset      : rising-edge clock, asynchronous active-high reset
//   flush             : drop the held instruction (valid=0, instruction=NOP)
//   hold              : keep every field unchanged
//   load              : capture instructionIn / pcIn
//   instructionIn     : word read from instruction memory
//   pcIn              : word address of instructionIn
//   IfIdInstruction   : captured instruction (NOP when not valid)
//   IfIdPC            : word address of IfIdInstruction
//   IfIdPCPlus1       : IfIdPC + 1
//   IfIdValid         : register holds a real instruction
// Priority is flush > hold > load; with none asserted the fields simply hold.
module if_id_register
  import mips_defs::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] instructionIn,
  input  logic [31:0] pcIn,
  output logic [31:0] IfIdInstruction,
  output logic [31:0] IfIdPC,
  output logic [31:0] IfIdPCPlus1,
  output logic        IfIdValid
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      IfIdInstruction <= Nop;
      IfIdPC          <= 32'd0;
      IfIdPCPlus1     <= 32'd0;
      IfIdValid       <= 1'b0;
    end else if (flush) begin
      // PC fields are left as-is; decode ignores them while IfIdValid is low.
      IfIdInstruction <= Nop;
      IfIdValid       <= 1'b0;
    end else if (hold) begin
      IfIdInstruction <= IfIdInstruction;
    end else if (load) begin
      IfIdInstruction <= instructionIn;
      IfIdPC          <= pcIn;
      IfIdPCPlus1     <= pcIn + 32'd1;
      IfIdValid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, addresses instruction memory and
// fills the IF/ID register. Handles stall, redirect (branch/jump), flush and
// halting once the PC runs past the end of the program.
// Ports:
//   Clock, Reset     : rising-edge clock, asynchronous active-high reset
//   ReadAddress      : word address to instruction memory (= PC)
//   Instruction      : memory word for ReadAddress, same cycle
//   Stall            : hold PC and IF/ID
//   RedirectValid    : branch taken / jump from execute
//   RedirectTarget   : next word address when RedirectValid
//   IfIdInstruction, IfIdPC, IfIdPCPlus1, IfIdValid : IF/ID register contents
//   Halted           : fetch FSM is in HALT
//   FetchCount       : saturating count of captured instructions
//                      (present only when FETCH_COUNT_EN is defined)
// Build option: `define FETCH_COUNT_EN to add the FetchCount output.
module instruction_fetch_unit
  import mips_defs::*;
#(
  parameter int unsigned MEM_WORDS = DefaultMemWords,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [31:0] ReadAddress,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] IfIdInstruction,
  output logic [31:0] IfIdPC,
  output logic [31:0] IfIdPCPlus1,
  output logic        IfIdValid,
`ifdef FETCH_COUNT_EN
  output logic [31:0] FetchCount,
`endif
  output logic        Halted
);

  fetchStateT  stateQ, stateD;
  logic [31:0] pcQ, pcD;
  logic        load, flush, hold;
  logic        pcPastEnd;
  logic        targetInRange;

  assign pcPastEnd     = (pcQ >= MEM_WORDS);
  assign targetInRange = (RedirectTarget < MEM_WORDS);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ <= StBoot;
      pcQ    <= RESET_PC;
    end else begin
      stateQ <= stateD;
      pcQ    <= pcD;
    end
  end

  always_comb begin
    stateD = stateQ;
    pcD    = pcQ;
    load   = 1'b0;
    flush  = 1'b0;
    hold   = 1'b0;
    unique case (stateQ)
      StBoot: begin
        if (RedirectValid) begin
          pcD = RedirectTarget;
        end
        stateD = StRun;
      end
      StRun: begin
        if (RedirectValid) begin
          // An out-of-range target is still taken; the halt check fires next cycle.
          pcD   = RedirectTarget;
          flush = 1'b1;
        end else if (pcPastEnd) begin
          // Never capture past the end of the program.
          stateD = StHalt;
          flush  = 1'b1;
        end else if (Stall) begin
          hold = 1'b1;
        end else begin
          load = 1'b1;
          pcD  = pcQ + 32'd1;
        end
      end
      StHalt: begin
        if (RedirectValid && targetInRange) begin
          pcD    = RedirectTarget;
          stateD = StRun;
        end
      end
      default: stateD = StBoot;
    endcase
  end

  if_id_register u_if_id_register (
    .Clock           (Clock),
    .Reset           (Reset),
    .flush           (flush),
    .hold            (hold),
    .load            (load),
    .instructionIn   (Instruction),
    .pcIn            (pcQ),
    .IfIdInstruction (IfIdInstruction),
    .IfIdPC          (IfIdPC),
    .IfIdPCPlus1     (IfIdPCPlus1),
    .IfIdValid       (IfIdValid)
  );

  assign ReadAddress = pcQ;
  assign Halted      = (stateQ == StHalt);

`ifdef FETCH_COUNT_EN
  logic [31:0] fetchCountQ;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      fetchCountQ <= 32'd0;
    end else if (load && (fetchCountQ != 32'hFFFF_FFFF)) begin
      fetchCountQ <= fetchCountQ + 32'd1;
    end
  end

  assign FetchCount = fetchCountQ;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  typedef struct {
    bit          onB;
    string       tag;
    bit          chkPc;
    logic [31:0] ra;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp1;
    logic        valid;
    logic        halted;
  } expT;

  expT expQ[$];
  int  assertCount = 0;
  int  failCount   = 0;

  logic        Clock = 1'b0;
  logic        Reset, ResetB;
  logic        Stall, StallB, RedirectValid, RedirectValidB;
  logic [31:0] RedirectTarget, RedirectTargetB;
  logic [31:0] raA, raB, instrA, instrB;
  logic [31:0] ifInstrA, ifInstrB, ifPcA, ifPcB, ifPcp1A, ifPcp1B;
  logic        ifValidA, ifValidB, haltedA, haltedB;
`ifdef FETCH_COUNT_EN
  logic [31:0] countA, countB;
`endif

  always #5 Clock = ~Clock;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'd0) return 32'h2009_0001;
    if (a == 32'd1) return 32'h200A_0007;
    if (a == 32'd2) return 32'h200B_0009;
    if (a < 32'd256) return 32'h1000_0000 + a;
    return 32'hBADC_0DE5;
  endfunction

  always_comb instrA = memWord(raA);
  always_comb instrB = memWord(raB);

  instruction_fetch_unit dutA (
    .Clock           (Clock),
    .Reset           (Reset),
    .ReadAddress     (raA),
    .Instruction     (instrA),
    .Stall           (Stall),
    .RedirectValid   (RedirectValid),
    .RedirectTarget  (RedirectTarget),
    .IfIdInstruction (ifInstrA),
    .IfIdPC          (ifPcA),
    .IfIdPCPlus1     (ifPcp1A),
    .IfIdValid       (ifValidA),
`ifdef FETCH_COUNT_EN
    .FetchCount      (countA),
`endif
    .Halted          (haltedA)
  );

  instruction_fetch_unit #(.MEM_WORDS(4)) dutB (
    .Clock           (Clock),
    .Reset           (ResetB),
    .ReadAddress     (raB),
    .Instruction     (instrB),
    .Stall           (StallB),
    .RedirectValid   (RedirectValidB),
    .RedirectTarget  (RedirectTargetB),
    .IfIdInstruction (ifInstrB),
    .IfIdPC          (ifPcB),
    .IfIdPCPlus1     (ifPcp1B),
    .IfIdValid       (ifValidB),
`ifdef FETCH_COUNT_EN
    .FetchCount      (countB),
`endif
    .Halted          (haltedB)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit onB, input string tag, input bit chkPc, input logic [31:0] ra,
                      input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pcp1,
                      input logic valid, input logic halted);
    expT e;
    e.onB = onB; e.tag = tag; e.chkPc = chkPc; e.ra = ra; e.instr = instr;
    e.pc = pc; e.pcp1 = pcp1; e.valid = valid; e.halted = halted;
    expQ.push_back(e);
  endtask

  // Expect a normal capture of the word at pc.
  task automatic pushFetch(input bit onB, input string tag, input logic [31:0] pc);
    push(onB, tag, 1'b1, pc + 32'd1, memWord(pc), pc, pc + 32'd1, 1'b1, 1'b0);
  endtask

  task automatic checkNow();
    expT e;
    if (expQ.size() == 0) begin
      failCount++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = expQ.pop_front();
    check({e.tag, ".ReadAddress"}, e.onB ? raB : raA, e.ra);
    check({e.tag, ".IfIdInstruction"}, e.onB ? ifInstrB : ifInstrA, e.instr);
    check({e.tag, ".IfIdValid"}, {31'd0, e.onB ? ifValidB : ifValidA}, {31'd0, e.valid});
    check({e.tag, ".Halted"}, {31'd0, e.onB ? haltedB : haltedA}, {31'd0, e.halted});
    if (e.chkPc) begin
      check({e.tag, ".IfIdPC"}, e.onB ? ifPcB : ifPcA, e.pc);
      check({e.tag, ".IfIdPCPlus1"}, e.onB ? ifPcp1B : ifPcp1A, e.pcp1);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    checkNow();
  endtask

  initial begin
    Reset = 1'b1; ResetB = 1'b1;
    Stall = 1'b0; StallB = 1'b0;
    RedirectValid = 1'b0; RedirectValidB = 1'b0;
    RedirectTarget = 32'd0; RedirectTargetB = 32'd0;

    // Reset values
    #2;
    push(1'b0, "reset", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkNow();
    #1 Reset = 1'b0;

    // Boot cycle, then free run
    push(1'b0, "boot", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); tick();
    pushFetch(1'b0, "run0", 32'd0); tick();
    pushFetch(1'b0, "run1", 32'd1); tick();

    // Stall three cycles with IfIdPC=1
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, "stall", 1'b1, 32'd2, memWord(32'd1), 32'd1, 32'd2, 1'b1, 1'b0);
      tick();
    end
    Stall = 1'b0;
    pushFetch(1'b0, "run2", 32'd2); tick();
    pushFetch(1'b0, "run3", 32'd3); tick();
    pushFetch(1'b0, "run4", 32'd4); tick();

    // Redirect beats a simultaneous stall at PC=5
    Stall = 1'b1; RedirectValid = 1'b1; RedirectTarget = 32'd8;
    push(1'b0, "redirStall", 1'b0, 32'd8, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); tick();
    Stall = 1'b0; RedirectValid = 1'b0;
    pushFetch(1'b0, "run8", 32'd8); tick();

    // Move to PC=6, then reset asynchronously between edges
    RedirectValid = 1'b1; RedirectTarget = 32'd6;
    push(1'b0, "redir6", 1'b0, 32'd6, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); tick();
    RedirectValid = 1'b0;
    Reset = 1'b1;
    #2;
    push(1'b0, "asyncReset", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkNow();
    #1 Reset = 1'b0;
    push(1'b0, "boot2", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); tick();

    // 5 advances, 2 stalls, 1 redirect
    for (int i = 0; i < 5; i++) begin
      pushFetch(1'b0, "cnt", i); tick();
    end
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, "cntStall", 1'b1, 32'd5, memWord(32'd4), 32'd4, 32'd5, 1'b1, 1'b0);
      tick();
    end
    Stall = 1'b0; RedirectValid = 1'b1; RedirectTarget = 32'd20;
    push(1'b0, "cntRedir", 1'b0, 32'd20, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); tick();
    RedirectValid = 1'b0;
`ifdef FETCH_COUNT_EN
    check("FetchCount5", countA, 32'd5);
    force dutA.fetchCountQ = 32'hFFFF_FFFE;
    #1;
    release dutA.fetchCountQ;
`endif
    for (int i = 20; i < 23; i++) begin
      pushFetch(1'b0, "sat", i); tick();
    end
`ifdef FETCH_COUNT_EN
    check("FetchCountSat", countA, 32'hFFFF_FFFF);
`endif

    // MEM_WORDS=4 instance: run off the end, halt, redirect in and out of range
    ResetB = 1'b0;
    push(1'b1, "bBoot", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      pushFetch(1'b1, "bRun", i); tick();
    end
    push(1'b1, "bHalt", 1'b0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1); tick();
    push(1'b1, "bHaltHold", 1'b0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1); tick();
    RedirectValidB = 1'b1; RedirectTargetB = 32'd2;
    push(1'b1, "bUnhalt", 1'b0, 32'd2, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); tick();
    RedirectValidB = 1'b0;
    pushFetch(1'b1, "bRun2", 32'd2); tick();
    pushFetch(1'b1, "bRun3", 32'd3); tick();
    push(1'b1, "bHalt2", 1'b0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1); tick();
    RedirectValidB = 1'b1; RedirectTargetB = 32'd9;
    push(1'b1, "bBadRedir", 1'b0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1); tick();
    RedirectValidB = 1'b0;
    push(1'b1, "bStayHalt", 1'b0, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
